// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer driving the instruction ROM.
// Optional FETCH_SEQ_PERF_EN adds InstCount/StallCount counters.
module fetch_sequencer #(
    parameter int          IW         = 16,
    parameter int          DW         = 9,
    parameter logic [IW-1:0] PROG0_BASE = '0,
    parameter logic [IW-1:0] PROG1_BASE = '0,
    parameter logic [IW-1:0] PROG2_BASE = '0,
    parameter logic [IW-1:0] PROG3_BASE = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic [DW-1:0] InstIn,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [IW-1:0] Target,
    output logic [IW-1:0] InstAddress,
    output logic [DW-1:0] InstOut,
    output logic          InstValid,
    output logic          Busy,
    output logic          Done
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]   InstCount,
    output logic [31:0]   StallCount
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] pc;
    logic [IW-1:0] base;
    logic          run;
    logic          accept;

    assign run    = (state == RUN);
    assign accept = Start && (state == IDLE || state == DONE);

    // Entry point chosen by ProgSel when a program is started.
    always_comb begin
        base = PROG0_BASE;
        case (ProgSel)
            2'd0:    base = PROG0_BASE;
            2'd1:    base = PROG1_BASE;
            2'd2:    base = PROG2_BASE;
            default: base = PROG3_BASE;
        endcase
    end

    // PC and state update; stall freezes everything, halt beats branch.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        pc    <= base;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        if (Halt)
                            state <= DONE;
                        else if (BranchEn)
                            pc <= BranchRel ? pc + Target : Target;
                        else
                            pc <= pc + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign InstAddress = pc;
    assign InstValid   = run && !Stall;
    assign InstOut     = InstValid ? InstIn : '0;
    assign Busy        = run;
    assign Done        = (state == DONE);

`ifdef FETCH_SEQ_PERF_EN
    // Saturating counters of issued instructions and stall cycles.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            InstCount  <= '0;
            StallCount <= '0;
        end else if (accept) begin
            InstCount  <= '0;
            StallCount <= '0;
        end else if (run) begin
            if (!Stall && InstCount != '1)
                InstCount <= InstCount + 32'd1;
            if (Stall && StallCount != '1)
                StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule
